// File: rtl/rob_commit_stage_pkg.sv
// Shared types and constants for the ROB commit stage: the retiring uOP
// bundle, the commit FSM states, and helpers for branch resolution.
package rob_commit_stage_pkg;

    localparam int PRF_W     = 6;
    localparam int ARCH_REGS = 32;
    localparam int PC_W      = 32;
    localparam int ARCH_W    = $clog2(ARCH_REGS);

    typedef struct packed {
        logic              valid;
        logic              committed;
        logic              busy;
        logic [PC_W-1:0]   pc;
        logic              wr_en;
        logic [ARCH_W-1:0] rd_arch;
        logic [PRF_W-1:0]  rd_phys;
        logic [PRF_W-1:0]  old_phys;
        logic              is_branch;
        logic              branch_taken;
        logic              pred_taken;
        logic [PC_W-1:0]   branch_addr;
        logic [PC_W-1:0]   pred_addr;
    } UOPBundle;

    localparam int UOP_W = $bits(UOPBundle);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_DS,
        ST_FLUSH,
        ST_RECOVER
    } commit_state_e;

    // A taken branch also mispredicts when it went somewhere other than predicted.
    function automatic logic is_mispredict(input UOPBundle u);
        return u.is_branch &&
               ((u.branch_taken != u.pred_taken) ||
                (u.branch_taken && (u.branch_addr != u.pred_addr)));
    endfunction

    // Not-taken branches resume after the delay slot.
    function automatic logic [PC_W-1:0] branch_target(input UOPBundle u);
        return u.branch_taken ? u.branch_addr : (u.pc + PC_W'(8));
    endfunction

endpackage

// File: rtl/rob_commit_stage_arat.sv
// Architectural rename table: two retire write ports, two walk read ports.
// Resets to the identity mapping arch i -> phys i.
module arat_regfile
    import rob_commit_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we0_i,
    input  logic [ARCH_W-1:0] waddr0_i,
    input  logic [PRF_W-1:0]  wdata0_i,
    input  logic              we1_i,
    input  logic [ARCH_W-1:0] waddr1_i,
    input  logic [PRF_W-1:0]  wdata1_i,
    input  logic [ARCH_W-1:0] raddr0_i,
    input  logic [ARCH_W-1:0] raddr1_i,
    output logic [PRF_W-1:0]  rdata0_o,
    output logic [PRF_W-1:0]  rdata1_o
);

    logic [PRF_W-1:0] map_q [ARCH_REGS];

    // Table update; slot 1 is written last so it wins when both slots hit one entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PRF_W'(i);
            end
        end else begin
            if (we0_i) map_q[waddr0_i] <= wdata0_i;
            if (we1_i) map_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = map_q[raddr0_i];
    assign rdata1_o = map_q[raddr1_i];

endmodule

// File: rtl/rob_commit_stage.sv
// Commit stage: retires up to two uOPs per cycle from the ROB head, owns the
// ARAT, returns superseded physical registers, and on a retiring branch
// mispredict waits for the delay slot, flushes, redirects and walks the ARAT.
module rob_commit_stage
    import rob_commit_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rob_valid,
    output logic              rob_ready,
    input  logic [UOP_W-1:0]  uop0,
    input  logic [UOP_W-1:0]  uop1,
    output logic              free_we0,
    output logic              free_we1,
    output logic [PRF_W-1:0]  free_preg0,
    output logic [PRF_W-1:0]  free_preg1,
    output logic              flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              rec_valid,
    output logic [ARCH_W-1:0] rec_arch0,
    output logic [ARCH_W-1:0] rec_arch1,
    output logic [PRF_W-1:0]  rec_phys0,
    output logic [PRF_W-1:0]  rec_phys1,
    output logic              rec_busy,
    output logic [31:0]       retire_cnt
);

    UOPBundle u0;
    UOPBundle u1;
    assign u0 = uop0;
    assign u1 = uop1;

    commit_state_e     state_q, state_d;
    logic              ds_slot_q, ds_slot_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [ARCH_W-1:0] rec_idx_q, rec_idx_d;

    logic              good0, good1_raw;
    logic              ret0, ret1;
    logic              ready_c;
    logic              arat_we0, arat_we1;
    logic              walk_d;
    logic [PRF_W-1:0]  walk_phys0, walk_phys1;

    logic              free_we0_q, free_we1_q;
    logic [PRF_W-1:0]  free_preg0_q, free_preg1_q;
    logic              flush_q, redirect_valid_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic              rec_valid_q, rec_busy_q;
    logic [ARCH_W-1:0] rec_arch0_q, rec_arch1_q;
    logic [PRF_W-1:0]  rec_phys0_q, rec_phys1_q;
    logic [31:0]       retire_cnt_q;

    // Slot 1 additionally needs slot 0 to be out of the way; that part
    // depends on whether slot 0 retires, so it is folded in below.
    assign good0     = u0.valid && !u0.committed && !u0.busy;
    assign good1_raw = u1.valid && !u1.committed && !u1.busy;

    // Commit FSM state and recovery bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            ds_slot_q <= 1'b0;
            tgt_q     <= '0;
            rec_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ds_slot_q <= ds_slot_d;
            tgt_q     <= tgt_d;
            rec_idx_q <= rec_idx_d;
        end
    end

    // Retire selection and next-state: while waiting for a delay slot only that slot may go.
    always_comb begin
        state_d   = state_q;
        ds_slot_d = ds_slot_q;
        tgt_d     = tgt_q;
        rec_idx_d = rec_idx_q;
        ret0      = 1'b0;
        ret1      = 1'b0;
        ready_c   = (state_q == ST_RUN) || (state_q == ST_WAIT_DS);

        if (rob_valid && ready_c) begin
            if (state_q == ST_RUN || !ds_slot_q) begin
                ret0 = good0;
            end
            if (state_q == ST_RUN || ds_slot_q) begin
                ret1 = good1_raw && (!u0.valid || u0.committed || ret0);
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (ret0 && is_mispredict(u0)) begin
                    tgt_d = branch_target(u0);
                    if (ret1) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d   = ST_WAIT_DS;
                        ds_slot_d = 1'b1;
                    end
                end else if (ret1 && is_mispredict(u1)) begin
                    tgt_d     = branch_target(u1);
                    state_d   = ST_WAIT_DS;
                    ds_slot_d = 1'b0;
                end
            end
            ST_WAIT_DS: begin
                if (ret0 || ret1) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d   = ST_RECOVER;
                rec_idx_d = '0;
            end
            ST_RECOVER: begin
                if (rec_idx_q == ARCH_W'(ARCH_REGS - 2)) begin
                    state_d   = ST_RUN;
                    rec_idx_d = '0;
                end else begin
                    rec_idx_d = rec_idx_q + ARCH_W'(2);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign rob_ready = ready_c;
    assign arat_we0  = ret0 && u0.wr_en && (u0.rd_arch != '0);
    assign arat_we1  = ret1 && u1.wr_en && (u1.rd_arch != '0);
    assign walk_d    = (state_d == ST_RECOVER);

    // Walk reads are addressed with next-cycle's index so the registered
    // restore outputs line up with the RECOVER cycles.
    arat_regfile u_arat (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we0_i    (arat_we0),
        .waddr0_i (u0.rd_arch),
        .wdata0_i (u0.rd_phys),
        .we1_i    (arat_we1),
        .waddr1_i (u1.rd_arch),
        .wdata1_i (u1.rd_phys),
        .raddr0_i (rec_idx_d),
        .raddr1_i ({rec_idx_d[ARCH_W-1:1], 1'b1}),
        .rdata0_o (walk_phys0),
        .rdata1_o (walk_phys1)
    );

    // Registered outputs: free-list returns, retire count, flush/redirect and restore walk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_we0_q       <= 1'b0;
            free_we1_q       <= 1'b0;
            free_preg0_q     <= '0;
            free_preg1_q     <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            rec_valid_q      <= 1'b0;
            rec_busy_q       <= 1'b0;
            rec_arch0_q      <= '0;
            rec_arch1_q      <= '0;
            rec_phys0_q      <= '0;
            rec_phys1_q      <= '0;
            retire_cnt_q     <= '0;
        end else begin
            free_we0_q       <= arat_we0;
            free_we1_q       <= arat_we1;
            free_preg0_q     <= arat_we0 ? u0.old_phys : '0;
            free_preg1_q     <= arat_we1 ? u1.old_phys : '0;
            flush_q          <= (state_d == ST_FLUSH);
            redirect_valid_q <= (state_d == ST_FLUSH);
            redirect_pc_q    <= (state_d == ST_FLUSH) ? tgt_d : '0;
            rec_valid_q      <= walk_d;
            rec_busy_q       <= walk_d;
            rec_arch0_q      <= walk_d ? rec_idx_d : '0;
            rec_arch1_q      <= walk_d ? {rec_idx_d[ARCH_W-1:1], 1'b1} : '0;
            rec_phys0_q      <= walk_d ? walk_phys0 : '0;
            rec_phys1_q      <= walk_d ? walk_phys1 : '0;
            retire_cnt_q     <= retire_cnt_q + {31'b0, ret0} + {31'b0, ret1};
        end
    end

    assign free_we0       = free_we0_q;
    assign free_we1       = free_we1_q;
    assign free_preg0     = free_preg0_q;
    assign free_preg1     = free_preg1_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign rec_valid      = rec_valid_q;
    assign rec_busy       = rec_busy_q;
    assign rec_arch0      = rec_arch0_q;
    assign rec_arch1      = rec_arch1_q;
    assign rec_phys0      = rec_phys0_q;
    assign rec_phys1      = rec_phys1_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_rob_commit_stage.sv
// Bench for rob_commit_stage: directed scenarios plus randomized retirement
// against a reference model (ARAT array, retire count, expected frees).
module tb_rob_commit_stage;
    import rob_commit_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rob_valid = 1'b0;
    UOPBundle          u0 = '0;
    UOPBundle          u1 = '0;
    logic              rob_ready;
    logic              free_we0, free_we1;
    logic [PRF_W-1:0]  free_preg0, free_preg1;
    logic              flush, redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              rec_valid, rec_busy;
    logic [ARCH_W-1:0] rec_arch0, rec_arch1;
    logic [PRF_W-1:0]  rec_phys0, rec_phys1;
    logic [31:0]       retire_cnt;

    int          vectors = 0;
    int          errors  = 0;
    int          arat_m [ARCH_REGS];
    int unsigned cnt_m;

    rob_commit_stage dut (
        .clk            (clk),
        .rst            (rst),
        .rob_valid      (rob_valid),
        .rob_ready      (rob_ready),
        .uop0           (u0),
        .uop1           (u1),
        .free_we0       (free_we0),
        .free_we1       (free_we1),
        .free_preg0     (free_preg0),
        .free_preg1     (free_preg1),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rec_valid      (rec_valid),
        .rec_arch0      (rec_arch0),
        .rec_arch1      (rec_arch1),
        .rec_phys0      (rec_phys0),
        .rec_phys1      (rec_phys1),
        .rec_busy       (rec_busy),
        .retire_cnt     (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) arat_m[i] = i;
        cnt_m = 0;
    endtask

    function automatic UOPBundle mk_op(input int rd, input int phys, input int old);
        UOPBundle u;
        u          = '0;
        u.valid    = 1'b1;
        u.wr_en    = 1'b1;
        u.pc       = 32'h1000;
        u.rd_arch  = ARCH_W'(rd);
        u.rd_phys  = PRF_W'(phys);
        u.old_phys = PRF_W'(old);
        return u;
    endfunction

    function automatic UOPBundle mk_br(input logic [PC_W-1:0] pc, input logic taken,
                                       input logic ptaken, input logic [PC_W-1:0] addr,
                                       input logic [PC_W-1:0] paddr);
        UOPBundle u;
        u              = '0;
        u.valid        = 1'b1;
        u.is_branch    = 1'b1;
        u.pc           = pc;
        u.branch_taken = taken;
        u.pred_taken   = ptaken;
        u.branch_addr  = addr;
        u.pred_addr    = paddr;
        return u;
    endfunction

    function automatic UOPBundle rnd_uop();
        UOPBundle u;
        u              = '0;
        u.valid        = ($urandom_range(0, 3) != 0);
        u.committed    = ($urandom_range(0, 9) == 0);
        u.busy         = ($urandom_range(0, 4) == 0);
        u.pc           = $urandom;
        u.wr_en        = ($urandom_range(0, 4) != 0);
        u.rd_arch      = ARCH_W'($urandom_range(0, ARCH_REGS - 1));
        u.rd_phys      = PRF_W'($urandom);
        u.old_phys     = PRF_W'($urandom);
        u.is_branch    = ($urandom_range(0, 4) == 0);
        u.branch_taken = 1'($urandom_range(0, 1));
        u.pred_taken   = u.branch_taken;
        u.branch_addr  = $urandom;
        // A not-taken branch is correct whatever address was predicted.
        u.pred_addr    = u.branch_taken ? u.branch_addr : $urandom;
        return u;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        vectors++;
        if ({free_we0, free_we1, flush, redirect_valid, rec_valid, rec_busy} !== 6'b0 ||
            free_preg0 !== '0 || free_preg1 !== '0 || redirect_pc !== '0) begin
            errors++;
            $display("FAIL reset_strobes got we=%b%b fl=%b rv=%b rec=%b%b p=%0d/%0d pc=%h want all 0",
                     free_we0, free_we1, flush, redirect_valid, rec_valid, rec_busy,
                     free_preg0, free_preg1, redirect_pc);
        end
        vectors++;
        if (rec_arch0 !== '0 || rec_arch1 !== '0 || rec_phys0 !== '0 || rec_phys1 !== '0 ||
            retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_rec got arch=%0d/%0d phys=%0d/%0d cnt=%0d want 0",
                     rec_arch0, rec_arch1, rec_phys0, rec_phys1, retire_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (rob_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", rob_ready);
        end
    endtask

    task automatic test_dual_retire();
        u0 = mk_op(3, 40, 3);
        u1 = mk_op(5, 41, 5);
        rob_valid = 1'b1;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        arat_m[3] = 40;
        arat_m[5] = 41;
        cnt_m += 2;
        vectors++;
        if (free_we0 !== 1'b1 || free_preg0 !== PRF_W'(3) || free_we1 !== 1'b1 ||
            free_preg1 !== PRF_W'(5)) begin
            errors++;
            $display("FAIL dual_free got we0=%b p0=%0d we1=%b p1=%0d want 1 3 1 5",
                     free_we0, free_preg0, free_we1, free_preg1);
        end
        vectors++;
        if (retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL dual_cnt got %0d want %0d", retire_cnt, cnt_m);
        end
        tick();
        vectors++;
        if (free_we0 !== 1'b0 || free_we1 !== 1'b0) begin
            errors++;
            $display("FAIL dual_free_drop got we0=%b we1=%b want 0 0", free_we0, free_we1);
        end
    endtask

    task automatic test_same_rd();
        u0 = mk_op(7, 42, 7);
        u1 = mk_op(7, 43, 42);
        rob_valid = 1'b1;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        arat_m[7] = 43;
        cnt_m += 2;
        vectors++;
        if (free_we0 !== 1'b1 || free_preg0 !== PRF_W'(7) || free_we1 !== 1'b1 ||
            free_preg1 !== PRF_W'(42) || retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL same_rd got we0=%b p0=%0d we1=%b p1=%0d cnt=%0d want 1 7 1 42 %0d",
                     free_we0, free_preg0, free_we1, free_preg1, retire_cnt, cnt_m);
        end
    endtask

    task automatic test_busy();
        u0 = mk_op(4, 50, 4);
        u0.busy = 1'b1;
        u1 = mk_op(6, 51, 6);
        rob_valid = 1'b1;
        tick();
        vectors++;
        if (free_we0 !== 1'b0 || free_we1 !== 1'b0 || retire_cnt !== cnt_m ||
            rob_ready !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL busy_block got we=%b%b cnt=%0d ready=%b flush=%b want 00 %0d 1 0",
                     free_we0, free_we1, retire_cnt, rob_ready, flush, cnt_m);
        end
        u1 = '0;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        vectors++;
        if (free_we0 !== 1'b0 || retire_cnt !== cnt_m || rob_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_alone got we0=%b cnt=%0d ready=%b want 0 %0d 1",
                     free_we0, retire_cnt, rob_ready, cnt_m);
        end
    endtask

    task automatic test_mispredict_slot0();
        u0 = mk_br(32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
        u1 = mk_op(9, 44, 9);
        rob_valid = 1'b1;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        arat_m[9] = 44;
        cnt_m += 2;
        vectors++;
        if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            errors++;
            $display("FAIL mp0_redirect got flush=%b rv=%b pc=%h want 1 1 00000200",
                     flush, redirect_valid, redirect_pc);
        end
        vectors++;
        if (free_we0 !== 1'b0 || free_we1 !== 1'b1 || free_preg1 !== PRF_W'(9) ||
            rob_ready !== 1'b0) begin
            errors++;
            $display("FAIL mp0_free got we0=%b we1=%b p1=%0d ready=%b want 0 1 9 0",
                     free_we0, free_we1, free_preg1, rob_ready);
        end
        for (int k = 0; k < ARCH_REGS / 2; k++) begin
            tick();
            vectors++;
            if (rec_valid !== 1'b1 || rec_busy !== 1'b1 || rob_ready !== 1'b0 || flush !== 1'b0) begin
                errors++;
                $display("FAIL mp0_walk_ctl k=%0d got v=%b b=%b ready=%b flush=%b want 1 1 0 0",
                         k, rec_valid, rec_busy, rob_ready, flush);
            end
            vectors++;
            if (rec_arch0 !== ARCH_W'(2 * k) || rec_arch1 !== ARCH_W'(2 * k + 1) ||
                rec_phys0 !== PRF_W'(arat_m[2 * k]) || rec_phys1 !== PRF_W'(arat_m[2 * k + 1])) begin
                errors++;
                $display("FAIL mp0_walk k=%0d got %0d->%0d %0d->%0d want %0d->%0d %0d->%0d",
                         k, rec_arch0, rec_phys0, rec_arch1, rec_phys1,
                         2 * k, arat_m[2 * k], 2 * k + 1, arat_m[2 * k + 1]);
            end
        end
        tick();
        vectors++;
        if (rec_valid !== 1'b0 || rec_busy !== 1'b0 || rob_ready !== 1'b1 || retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL mp0_end got v=%b b=%b ready=%b cnt=%0d want 0 0 1 %0d",
                     rec_valid, rec_busy, rob_ready, retire_cnt, cnt_m);
        end
    endtask

    task automatic test_mispredict_slot1();
        int guard;
        u0 = mk_op(10, 45, 10);
        u1 = mk_br(32'h104, 1'b0, 1'b1, 32'h0, 32'h300);
        rob_valid = 1'b1;
        tick();
        arat_m[10] = 45;
        cnt_m += 2;
        vectors++;
        if (free_we0 !== 1'b1 || free_preg0 !== PRF_W'(10) || flush !== 1'b0 || rob_ready !== 1'b1) begin
            errors++;
            $display("FAIL mp1_wait got we0=%b p0=%0d flush=%b ready=%b want 1 10 0 1",
                     free_we0, free_preg0, flush, rob_ready);
        end
        // Slot 1 is good but is not the delay slot, so it must stay put.
        u0 = '0;
        u1 = mk_op(12, 47, 12);
        tick();
        vectors++;
        if (free_we1 !== 1'b0 || retire_cnt !== cnt_m || flush !== 1'b0) begin
            errors++;
            $display("FAIL mp1_hold got we1=%b cnt=%0d flush=%b want 0 %0d 0",
                     free_we1, retire_cnt, flush, cnt_m);
        end
        u0 = mk_op(11, 46, 11);
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        arat_m[11] = 46;
        cnt_m += 1;
        vectors++;
        if (free_we0 !== 1'b1 || free_preg0 !== PRF_W'(11) || free_we1 !== 1'b0 ||
            flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h10C) begin
            errors++;
            $display("FAIL mp1_ds got we0=%b p0=%0d we1=%b flush=%b rv=%b pc=%h want 1 11 0 1 1 0000010c",
                     free_we0, free_preg0, free_we1, flush, redirect_valid, redirect_pc);
        end
        vectors++;
        if (retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL mp1_cnt got %0d want %0d", retire_cnt, cnt_m);
        end
        guard = 0;
        while (rob_ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard != ARCH_REGS / 2 + 1) begin
            errors++;
            $display("FAIL mp1_walk_len got %0d cycles not ready want %0d", guard, ARCH_REGS / 2 + 1);
        end
    endtask

    task automatic test_random();
        logic e0, e1, ew0, ew1;
        UOPBundle s0, s1;
        for (int n = 0; n < 400; n++) begin
            s0 = rnd_uop();
            s1 = rnd_uop();
            u0 = s0;
            u1 = s1;
            rob_valid = ($urandom_range(0, 6) != 0);
            e0  = rob_valid && s0.valid && !s0.committed && !s0.busy;
            e1  = rob_valid && s1.valid && !s1.committed && !s1.busy &&
                  (!s0.valid || s0.committed || e0);
            ew0 = e0 && s0.wr_en && (s0.rd_arch != 0);
            ew1 = e1 && s1.wr_en && (s1.rd_arch != 0);
            #1;
            vectors++;
            if (rob_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready n=%0d got %b want 1", n, rob_ready);
            end
            tick();
            if (ew0) arat_m[s0.rd_arch] = int'(s0.rd_phys);
            if (ew1) arat_m[s1.rd_arch] = int'(s1.rd_phys);
            cnt_m += int'(e0) + int'(e1);
            vectors++;
            if (free_we0 !== ew0 || (ew0 && free_preg0 !== s0.old_phys) ||
                free_we1 !== ew1 || (ew1 && free_preg1 !== s1.old_phys)) begin
                errors++;
                $display("FAIL rnd_free n=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         n, free_we0, free_preg0, free_we1, free_preg1,
                         ew0, s0.old_phys, ew1, s1.old_phys);
            end
            vectors++;
            if (retire_cnt !== cnt_m || flush !== 1'b0) begin
                errors++;
                $display("FAIL rnd_cnt n=%0d got cnt=%0d flush=%b want %0d 0", n, retire_cnt, flush, cnt_m);
            end
        end
        // Mispredict alone in slot 0: its delay slot arrives in slot 1 next beat.
        u0 = mk_br(32'h400, 1'b1, 1'b0, 32'h480, 32'h0);
        u1 = '0;
        rob_valid = 1'b1;
        tick();
        cnt_m += 1;
        vectors++;
        if (flush !== 1'b0 || rob_ready !== 1'b1 || retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL ds1_wait got flush=%b ready=%b cnt=%0d want 0 1 %0d",
                     flush, rob_ready, retire_cnt, cnt_m);
        end
        u0.committed = 1'b1;
        u1 = mk_op(20, 50, 33);
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        arat_m[20] = 50;
        cnt_m += 1;
        vectors++;
        if (free_we1 !== 1'b1 || free_preg1 !== PRF_W'(33) || free_we0 !== 1'b0 ||
            flush !== 1'b1 || redirect_pc !== 32'h480) begin
            errors++;
            $display("FAIL ds1_flush got we1=%b p1=%0d we0=%b flush=%b pc=%h want 1 33 0 1 00000480",
                     free_we1, free_preg1, free_we0, flush, redirect_pc);
        end
        for (int k = 0; k < ARCH_REGS / 2; k++) begin
            tick();
            vectors++;
            if (rec_valid !== 1'b1 || rec_arch0 !== ARCH_W'(2 * k) || rec_arch1 !== ARCH_W'(2 * k + 1) ||
                rec_phys0 !== PRF_W'(arat_m[2 * k]) || rec_phys1 !== PRF_W'(arat_m[2 * k + 1])) begin
                errors++;
                $display("FAIL rnd_walk k=%0d got v=%b %0d->%0d %0d->%0d want 1 %0d->%0d %0d->%0d",
                         k, rec_valid, rec_arch0, rec_phys0, rec_arch1, rec_phys1,
                         2 * k, arat_m[2 * k], 2 * k + 1, arat_m[2 * k + 1]);
            end
        end
        tick();
        vectors++;
        if (rec_valid !== 1'b0 || rob_ready !== 1'b1 || retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL rnd_end got v=%b ready=%b cnt=%0d want 0 1 %0d",
                     rec_valid, rob_ready, retire_cnt, cnt_m);
        end
    endtask

    task automatic test_reset_midwalk();
        u0 = mk_br(32'h500, 1'b0, 1'b1, 32'h0, 32'h900);
        u1 = mk_op(15, 60, 15);
        rob_valid = 1'b1;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        for (int k = 0; k <= 5; k++) tick();
        vectors++;
        if (rec_valid !== 1'b1 || rec_arch0 !== ARCH_W'(10)) begin
            errors++;
            $display("FAIL midwalk_pre got v=%b arch0=%0d want 1 10", rec_valid, rec_arch0);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({free_we0, free_we1, flush, redirect_valid, rec_valid, rec_busy} !== 6'b0 ||
            rec_arch0 !== '0 || rec_arch1 !== '0 || rec_phys0 !== '0 || rec_phys1 !== '0 ||
            redirect_pc !== '0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midwalk_rst got st=%b arch=%0d/%0d phys=%0d/%0d pc=%h cnt=%0d want all 0",
                     {free_we0, free_we1, flush, redirect_valid, rec_valid, rec_busy},
                     rec_arch0, rec_arch1, rec_phys0, rec_phys1, redirect_pc, retire_cnt);
        end
        model_reset();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (rob_ready !== 1'b1 || rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL midwalk_release got ready=%b v=%b want 1 0", rob_ready, rec_valid);
        end
        // A write-free mispredict walks the table to show it is back to identity.
        u0 = mk_br(32'h600, 1'b1, 1'b0, 32'h700, 32'h0);
        u1 = mk_op(0, 61, 0);
        rob_valid = 1'b1;
        tick();
        rob_valid = 1'b0;
        u0 = '0;
        u1 = '0;
        cnt_m += 2;
        vectors++;
        if (redirect_pc !== 32'h700 || free_we1 !== 1'b0 || retire_cnt !== cnt_m) begin
            errors++;
            $display("FAIL midwalk_redo got pc=%h we1=%b cnt=%0d want 00000700 0 %0d",
                     redirect_pc, free_we1, retire_cnt, cnt_m);
        end
        for (int k = 0; k < ARCH_REGS / 2; k++) begin
            tick();
            vectors++;
            if (rec_valid !== 1'b1 || rec_phys0 !== PRF_W'(arat_m[2 * k]) ||
                rec_phys1 !== PRF_W'(arat_m[2 * k + 1])) begin
                errors++;
                $display("FAIL ident_walk k=%0d got v=%b %0d %0d want 1 %0d %0d",
                         k, rec_valid, rec_phys0, rec_phys1, arat_m[2 * k], arat_m[2 * k + 1]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_dual_retire();
        test_same_rd();
        test_busy();
        test_mispredict_slot0();
        test_mispredict_slot1();
        test_random();
        test_reset_midwalk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
